// File: rtl/chip8_sprite_if.sv
// Bus bundle between a CPU/host and the DXYN sprite engine.
//   master : host side. Drives the draw command and returns memory/framebuffer read data.
//   slave  : engine side. Drives busy/done/collision and the memory and framebuffer strobes.
// Command : start, x, y, n, base_addr, wrap_en -> busy, done, collision
// Memory  : mem_rd, mem_addr -> mem_data (valid the cycle after mem_rd)
// Frame   : fb_rd, fb_wr, fb_row, fb_wdata -> fb_rdata (valid the cycle after fb_rd)
interface chip8_sprite_if #(
  parameter int SCR_W  = 64,
  parameter int SCR_H  = 32,
  parameter int ADDR_W = 12
);
  localparam int YW = $clog2(SCR_H);

  logic              start;
  logic [7:0]        x;
  logic [7:0]        y;
  logic [3:0]        n;
  logic [ADDR_W-1:0] base_addr;
  logic              wrap_en;
  logic              busy;
  logic              done;
  logic              collision;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic              fb_rd;
  logic              fb_wr;
  logic [YW-1:0]     fb_row;
  logic [SCR_W-1:0]  fb_rdata;
  logic [SCR_W-1:0]  fb_wdata;

  modport master (
    output start, x, y, n, base_addr, wrap_en, mem_data, fb_rdata,
    input  busy, done, collision, mem_rd, mem_addr, fb_rd, fb_wr, fb_row, fb_wdata
  );

  modport slave (
    input  start, x, y, n, base_addr, wrap_en, mem_data, fb_rdata,
    output busy, done, collision, mem_rd, mem_addr, fb_rd, fb_wr, fb_row, fb_wdata
  );
endinterface

// File: rtl/chip8_sprite_engine.sv
// CHIP-8 / SCHIP DXYN sprite draw engine.
// On start it latches the draw command, then for each sprite row it fetches
// one or two sprite bytes from main memory, reads the target framebuffer row,
// and writes it back XORed with the shifted sprite mask. Collision (VF) is
// the OR over all rows of any lit pixel that the sprite turned off.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : chip8_sprite_if.slave (command, memory and framebuffer buses)
// Parameters: SCR_W/SCR_H screen size (powers of two), ADDR_W memory address
// width, BIG_SPRITES enables the 16x16 sprite for n==0.
module chip8_sprite_engine #(
  parameter int SCR_W       = 64,
  parameter int SCR_H       = 32,
  parameter int ADDR_W      = 12,
  parameter int BIG_SPRITES = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  chip8_sprite_if.slave  bus
);
  localparam int XW = $clog2(SCR_W);
  localparam int YW = $clog2(SCR_H);
  localparam int CW = XW + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH0, S_FETCH1, S_FBRD, S_WRITE, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [XW-1:0]     x0_q, x0_d;
  logic [YW-1:0]     y0_q, y0_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              wrap_q, wrap_d;
  logic              wide_q, wide_d;     // 16-pixel rows, two bytes per row
  logic [4:0]        rows_q, rows_d;
  logic [4:0]        r_q, r_d;
  logic [15:0]       spr_q, spr_d;       // [15:8] = left byte, bit 15 = leftmost pixel
  logic              coll_q, coll_d;

  logic [4:0]        r_nxt;
  logic [ADDR_W-1:0] rd_base;
  logic [YW-1:0]     row_addr;
  logic              clip_nxt;
  logic [SCR_W-1:0]  mask;
  logic [CW-1:0]     col;

  assign r_nxt    = r_q + 5'd1;
  assign rd_base  = wide_q ? (base_q + ADDR_W'({r_q, 1'b0})) : (base_q + ADDR_W'(r_q));
  assign row_addr = y0_q + YW'(r_q);     // power-of-two height: truncation is the wrap
  // Next row falls off the bottom edge in clip mode.
  assign clip_nxt = !wrap_q && ((8'(y0_q) + 8'(r_nxt)) >= 8'(SCR_H));

  // Sprite pixel p lands on column x0+p. The carry bit of col marks
  // overflow past the right edge; the low bits are then already c-SCR_W.
  always_comb begin
    mask = '0;
    col  = '0;
    for (int p = 0; p < 16; p++) begin
      col = CW'(x0_q) + CW'(p);
      if (spr_q[15-p] && (!col[XW] || wrap_q))
        mask = mask | (SCR_W'(1) << col[XW-1:0]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      x0_q    <= '0;
      y0_q    <= '0;
      base_q  <= '0;
      wrap_q  <= 1'b0;
      wide_q  <= 1'b0;
      rows_q  <= '0;
      r_q     <= '0;
      spr_q   <= '0;
      coll_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      base_q  <= base_d;
      wrap_q  <= wrap_d;
      wide_q  <= wide_d;
      rows_q  <= rows_d;
      r_q     <= r_d;
      spr_q   <= spr_d;
      coll_q  <= coll_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    x0_d         = x0_q;
    y0_d         = y0_q;
    base_d       = base_q;
    wrap_d       = wrap_q;
    wide_d       = wide_q;
    rows_d       = rows_q;
    r_d          = r_q;
    spr_d        = spr_q;
    coll_d       = coll_q;
    bus.mem_rd   = 1'b0;
    bus.mem_addr = '0;
    bus.fb_rd    = 1'b0;
    bus.fb_wr    = 1'b0;
    bus.fb_row   = '0;
    bus.fb_wdata = '0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          // Start coordinate always wraps onto the screen.
          x0_d   = XW'(bus.x);
          y0_d   = YW'(bus.y);
          base_d = bus.base_addr;
          wrap_d = bus.wrap_en;
          coll_d = 1'b0;
          r_d    = '0;
          if (bus.n != 4'd0) begin
            rows_d  = {1'b0, bus.n};
            wide_d  = 1'b0;
            state_d = S_FETCH0;
          end else if (BIG_SPRITES != 0) begin
            rows_d  = 5'd16;
            wide_d  = 1'b1;
            state_d = S_FETCH0;
          end else begin
            rows_d  = '0;
            wide_d  = 1'b0;
            state_d = S_DONE;
          end
        end
      end
      S_FETCH0: begin
        bus.mem_rd   = 1'b1;
        bus.mem_addr = rd_base;
        state_d      = wide_q ? S_FETCH1 : S_FBRD;
      end
      S_FETCH1: begin
        spr_d[15:8]  = bus.mem_data;
        bus.mem_rd   = 1'b1;
        bus.mem_addr = rd_base + ADDR_W'(1);
        state_d      = S_FBRD;
      end
      S_FBRD: begin
        if (wide_q) spr_d[7:0] = bus.mem_data;
        else        spr_d      = {bus.mem_data, 8'h00};
        bus.fb_rd  = 1'b1;
        bus.fb_row = row_addr;
        state_d    = S_WRITE;
      end
      S_WRITE: begin
        bus.fb_wr    = 1'b1;
        bus.fb_row   = row_addr;
        bus.fb_wdata = bus.fb_rdata ^ mask;
        coll_d       = coll_q | (|(bus.fb_rdata & mask));
        r_d          = r_nxt;
        state_d      = ((r_nxt < rows_q) && !clip_nxt) ? S_FETCH0 : S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.collision = coll_q;
endmodule

// File: tb/tb_chip8_sprite_engine.sv
// Scoreboard bench for chip8_sprite_engine (64x32, big sprites on) plus a
// second 128x64 instance with big sprites off for the n==0 no-op path.
// The stimulus process runs a pixel-level reference model and queues the
// expected reads, row writes and completion; a monitor pops and compares.
module tb_chip8_sprite_engine;
  localparam int W  = 64;
  localparam int H  = 32;
  localparam int AW = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  chip8_sprite_if #(.SCR_W(W), .SCR_H(H), .ADDR_W(AW)) bus ();
  chip8_sprite_engine #(.SCR_W(W), .SCR_H(H), .ADDR_W(AW), .BIG_SPRITES(1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave));

  chip8_sprite_if #(.SCR_W(128), .SCR_H(64), .ADDR_W(AW)) bus_nb ();
  chip8_sprite_engine #(.SCR_W(128), .SCR_H(64), .ADDR_W(AW), .BIG_SPRITES(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .bus(bus_nb.slave));
  assign bus_nb.mem_data = 8'h00;
  assign bus_nb.fb_rdata = '0;

  typedef struct { int row; logic [W-1:0] data; } wr_t;
  typedef struct { int cyc; logic coll; } dn_t;

  logic [7:0]   mem [4096];
  logic [W-1:0] fb_dev [H];
  logic [W-1:0] fb_load_val [H];
  logic [W-1:0] ref_fb [H];
  bit           fb_load = 1'b0;
  bit           mon_en = 1'b0;
  wr_t          exp_wr_q [$];
  int           exp_rd_q [$];
  dn_t          exp_dn_q [$];
  logic         last_coll = 1'b0;
  int           cyc = 0;
  int           nvec = 0;
  int           nerr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory and framebuffer devices: one-cycle read latency.
  always @(posedge clk) begin
    if (bus.mem_rd) bus.mem_data <= mem[bus.mem_addr];
    if (bus.fb_rd)  bus.fb_rdata <= fb_dev[bus.fb_row];
    if (bus.fb_wr)  fb_dev[bus.fb_row] <= bus.fb_wdata;
    if (fb_load) for (int i = 0; i < H; i++) fb_dev[i] <= fb_load_val[i];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm);
    nvec++;
    nerr++;
    $display("FAIL %s: got an unexpected event, want none", nm);
  endtask

  // Monitor: compare every DUT strobe against the scoreboard queues.
  always @(negedge clk) begin
    if (mon_en) begin
      if (int'(bus.mem_rd) + int'(bus.fb_rd) + int'(bus.fb_wr) > 1) flag("strobe_overlap");
      if (bus.mem_rd) begin
        if (exp_rd_q.size() == 0) flag("extra_mem_rd");
        else chk("mem_addr", 64'(bus.mem_addr), 64'(exp_rd_q.pop_front()));
      end
      if (bus.fb_wr) begin
        if (exp_wr_q.size() == 0) flag("extra_fb_wr");
        else begin
          wr_t e;
          e = exp_wr_q.pop_front();
          chk("fb_row", 64'(bus.fb_row), 64'(e.row));
          chk("fb_wdata", 64'(bus.fb_wdata), 64'(e.data));
        end
      end
      if (bus.done) begin
        if (exp_dn_q.size() == 0) flag("extra_done");
        else begin
          dn_t d;
          d = exp_dn_q.pop_front();
          chk("done_cycle", 64'(cyc), 64'(d.cyc));
          chk("collision", 64'(bus.collision), 64'(d.coll));
          chk("busy_at_done", 64'(bus.busy), 64'd0);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Reference: plain pixel loop over the sprite, rows stop at the bottom
  // edge in clip mode; n==0 is a 16x16 sprite on this instance.
  task automatic model(input int x, input int y, input int n, input int base,
                       input bit wrap, input int at_cyc);
    int   x0, y0, rows, bpr, written;
    logic coll;
    dn_t  d;
    x0 = x % W;
    y0 = y % H;
    written = 0;
    coll = 1'b0;
    if (n == 0) begin rows = 16; bpr = 2; end
    else begin rows = n; bpr = 1; end
    for (int i = 0; i < rows; i++) begin
      int           ry;
      logic [W-1:0] tog;
      logic [15:0]  bits;
      wr_t          e;
      ry = y0 + i;
      if (ry >= H) begin
        if (!wrap) break;
        ry -= H;
      end
      bits = '0;
      for (int b = 0; b < bpr; b++) begin
        int a;
        a = (base + i * bpr + b) % 4096;
        exp_rd_q.push_back(a);
        bits[15 - 8*b -: 8] = mem[a];
      end
      tog = '0;
      for (int p = 0; p < 8 * bpr; p++) begin
        if (bits[15-p]) begin
          int c;
          c = x0 + p;
          if (c >= W) begin
            if (!wrap) continue;
            c -= W;
          end
          tog[c] = 1'b1;
        end
      end
      if ((ref_fb[ry] & tog) != '0) coll = 1'b1;
      ref_fb[ry] ^= tog;
      e.row = ry;
      e.data = ref_fb[ry];
      exp_wr_q.push_back(e);
      written++;
    end
    d.cyc = at_cyc + 1 + ((bpr == 2) ? 4 : 3) * written;
    d.coll = coll;
    exp_dn_q.push_back(d);
    last_coll = coll;
  endtask

  task automatic issue(input int x, input int y, input int n, input int base, input bit wrap);
    model(x, y, n, base, wrap, cyc);
    bus.x = 8'(x);
    bus.y = 8'(y);
    bus.n = 4'(n);
    bus.base_addr = AW'(base);
    bus.wrap_en = wrap;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (exp_dn_q.size() != 0 && k < 300) begin
      tick();
      k++;
    end
    if (exp_dn_q.size() != 0) begin
      flag("done_timeout");
      exp_dn_q.delete();
    end
    tick();
    tick();
    chk("rd_left", 64'(exp_rd_q.size()), 64'd0);
    chk("wr_left", 64'(exp_wr_q.size()), 64'd0);
    chk("coll_hold", 64'(bus.collision), 64'(last_coll));
    exp_rd_q.delete();
    exp_wr_q.delete();
  endtask

  task automatic load_fb(input bit rnd);
    for (int i = 0; i < H; i++) begin
      fb_load_val[i] = rnd ? W'({$urandom, $urandom}) : '0;
      ref_fb[i] = fb_load_val[i];
    end
    fb_load = 1'b1;
    tick();
    fb_load = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string nm);
    chk({nm, "_ctl"}, 64'({bus.busy, bus.done, bus.collision, bus.mem_rd, bus.fb_rd, bus.fb_wr}), 64'd0);
    chk({nm, "_addr"}, 64'({bus.mem_addr, bus.fb_row}), 64'd0);
    chk({nm, "_wdata"}, 64'(bus.fb_wdata), 64'd0);
  endtask

  initial begin
    int cnt, k;
    bus.start = 1'b0; bus.x = '0; bus.y = '0; bus.n = '0; bus.base_addr = '0; bus.wrap_en = 1'b0;
    bus_nb.start = 1'b0; bus_nb.x = '0; bus_nb.y = '0; bus_nb.n = '0;
    bus_nb.base_addr = '0; bus_nb.wrap_en = 1'b0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    repeat (3) tick();
    chk_idle_outputs("reset");
    rst_n = 1'b1;
    tick();
    mon_en = 1'b1;

    // Single row, then the same draw again to erase it and collide.
    load_fb(1'b0);
    mem[12'h300] = 8'hF0;
    issue(0, 0, 1, 12'h300, 1'b0);
    wait_done();
    issue(0, 0, 1, 12'h300, 1'b0);
    wait_done();

    // Right edge: clip, then wrap.
    mem[12'h310] = 8'hFF;
    load_fb(1'b0);
    issue(62, 3, 1, 12'h310, 1'b0);
    wait_done();
    issue(62, 4, 1, 12'h310, 1'b1);
    wait_done();

    // Bottom edge: clip, then wrap.
    issue(7, 30, 4, 12'h320, 1'b0);
    wait_done();
    issue(7, 30, 4, 12'h320, 1'b1);
    wait_done();

    // 16x16 sprite, start coordinate wraps (134 mod 64 = 6).
    load_fb(1'b1);
    issue(134, 40, 0, 12'h200, 1'b0);
    wait_done();
    // Memory address wraps past the top of the address space.
    issue(20, 9, 0, 12'hFF5, 1'b1);
    wait_done();

    // n==0 without big sprites: done in cycle 1, no strobes.
    bus_nb.x = 8'd3; bus_nb.y = 8'd3; bus_nb.n = 4'd0; bus_nb.start = 1'b1;
    tick();
    bus_nb.start = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      chk("nb_done", 64'(bus_nb.done), 64'(c == 1));
      chk("nb_strobes", 64'({bus_nb.busy, bus_nb.mem_rd, bus_nb.fb_rd, bus_nb.fb_wr, bus_nb.collision}), 64'd0);
      tick();
    end

    // Start while busy and start during DONE are both ignored.
    issue(10, 5, 3, 12'h500, 1'b0);
    tick();
    tick();
    bus.x = 8'd40; bus.n = 4'd9; bus.base_addr = 12'h123; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done();
    issue(50, 20, 2, 12'h540, 1'b1);
    k = 0;
    while (!bus.done && k < 100) begin tick(); k++; end
    if (!bus.done) flag("done_wait_timeout");
    bus.n = 4'd5; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (6) tick();
    wait_done();

    // Reset during the write of row 2, then a clean restart.
    load_fb(1'b1);
    issue(5, 0, 5, 12'h400, 1'b1);
    cnt = 0;
    k = 0;
    while (cnt < 3 && k < 100) begin
      tick();
      k++;
      if (bus.fb_wr) cnt++;
    end
    if (cnt < 3) flag("row2_wait_timeout");
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("mid_reset");
    exp_rd_q.delete();
    exp_wr_q.delete();
    exp_dn_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    last_coll = 1'b0;
    chk("coll_after_reset", 64'(bus.collision), 64'd0);
    mon_en = 1'b1;
    load_fb(1'b1);
    issue(33, 17, 6, 12'h420, 1'b0);
    wait_done();

    // Randomized draws.
    for (int t = 0; t < 60; t++) begin
      if (t % 10 == 0) load_fb(1'b1);
      issue(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 15)), int'($urandom_range(0, 4095)),
            1'($urandom_range(0, 1)));
      wait_done();
    end

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
